// File: rtl/event_blinker.sv
// event_blinker
//   Stretches one-cycle event strobes into LED blinks a person can see.
//   Every blink is ON_CYCLES high followed by a GAP_CYCLES forced-low gap.
//   Events that arrive while a blink is running wait in a saturating
//   pending count. An event that finds the count full is dropped, and the
//   drop sets a sticky overflow flag.
//   All state changes on the falling edge of clk.
//
// Ports
//   clk      in   system clock (falling-edge active)
//   rst_n    in   asynchronous active-low reset
//   evt_in   in   event strobe; each high sample on a falling edge is one event
//   clr_ovf  in   synchronous clear of overflow
//   led_out  out  registered blink output
//   busy     out  high whenever the FSM is not IDLE
//   pending  out  events queued but not yet started
//   overflow out  sticky flag: an event was dropped on a full queue
//
// state | meaning
// IDLE  | no blink running, queue empty
// ON    | led_out high, counting ON_CYCLES
// GAP   | led_out forced low, counting GAP_CYCLES
module event_blinker #(
  parameter int CNT_W      = 16,
  parameter int ON_CYCLES  = 32768,
  parameter int GAP_CYCLES = 32768,
  parameter int QUEUE_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               evt_in,
  input  logic               clr_ovf,
  output logic               led_out,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] PEND_MAX  = '1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [QUEUE_W-1:0] r_pend;
  logic               r_ovf;
  logic               r_led;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [QUEUE_W-1:0] w_pend_nxt;
  logic               w_ovf_nxt;
  logic               w_led_nxt;
  logic               w_start;
  logic               w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (evt_in || (r_pend != '0)) begin
          w_state_nxt = ON;
          w_start     = 1'b1;
        end
      end
      ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (evt_in || (r_pend != '0)) begin
            w_state_nxt = ON;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A blink start takes the live event first; the queue is only drawn
    // down when no event is present on that edge.
    w_pend_nxt = r_pend;
    w_drop     = 1'b0;
    if (w_start) begin
      if (!evt_in) begin
        w_pend_nxt = r_pend - QUEUE_W'(1);
      end
    end else if (evt_in) begin
      if (r_pend == PEND_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_pend_nxt = r_pend + QUEUE_W'(1);
      end
    end

    // A drop on the same edge as a clear keeps the flag set.
    w_ovf_nxt = r_ovf;
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      w_ovf_nxt = 1'b0;
    end

    w_led_nxt = (w_state_nxt == ON);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign led_out  = r_led;
  assign busy     = (r_state != IDLE);
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_event_blinker.sv
module tb_event_blinker;
  logic       clk;
  logic       rst_n;
  logic       evt_in;
  logic       clr_ovf;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  event_blinker #(
    .CNT_W(16),
    .ON_CYCLES(3),
    .GAP_CYCLES(2),
    .QUEUE_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .evt_in(evt_in),
    .clr_ovf(clr_ovf),
    .led_out(led_out),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Advance past the next active (falling) edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    evt_in  = 1'b0;
    clr_ovf = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    evt_in  = 1'b0;
    clr_ovf = 1'b0;
    #2;
    checks++;
    if ({led_out, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {led_out, busy, pending, overflow});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({led_out, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle_after_release: got %b expected 00000", {led_out, busy, pending, overflow});
    end
  endtask

  task automatic test_single();
    apply_reset();
    evt_in = 1'b1;
    tick();
    evt_in = 1'b0;
    // edge k=0 is the sampling edge; led high k=0..2, busy high k=0..4
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checks++;
      if (led_out !== (k < 3)) begin
        errors++;
        $display("FAIL single_led edge %0d: got %b expected %b", k, led_out, (k < 3));
      end
      checks++;
      if (busy !== (k < 5)) begin
        errors++;
        $display("FAIL single_busy edge %0d: got %b expected %b", k, busy, (k < 5));
      end
      checks++;
      if (pending !== 2'd0) begin
        errors++;
        $display("FAIL single_pending edge %0d: got %0d expected 0", k, pending);
      end
    end
  endtask

  // n back-to-back pulses from IDLE; blinks must start every 5 edges.
  task automatic test_burst(input int n);
    int  blinks;
    logic prev;
    logic exp_ovf;
    apply_reset();
    blinks  = 0;
    prev    = 1'b0;
    exp_ovf = (n > 4);
    for (int e = 0; e < 30; e++) begin
      evt_in = (e < n);
      tick();
      if (led_out && !prev) begin
        checks++;
        if (e != 5 * blinks) begin
          errors++;
          $display("FAIL burst%0d_period: blink %0d started edge %0d expected %0d", n, blinks, e, 5 * blinks);
        end
        blinks++;
      end
      prev = led_out;
      if (e <= 3) begin
        checks++;
        if (pending !== 2'(e)) begin
          errors++;
          $display("FAIL burst%0d_pending edge %0d: got %0d expected %0d", n, e, pending, e);
        end
      end
      if (e == 4) begin
        checks++;
        if (pending !== 2'd3 || overflow !== exp_ovf) begin
          errors++;
          $display("FAIL burst%0d_edge4: pending %0d ovf %b expected pending 3 ovf %b", n, pending, overflow, exp_ovf);
        end
      end
    end
    evt_in = 1'b0;
    checks++;
    if (blinks != 4) begin
      errors++;
      $display("FAIL burst%0d_count: got %0d blinks expected 4", n, blinks);
    end
    checks++;
    if (busy !== 1'b0 || pending !== 2'd0 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL burst%0d_final: busy %b pending %0d ovf %b expected 0 0 %b", n, busy, pending, overflow, exp_ovf);
    end
  endtask

  task automatic test_evt_at_gap_end();
    apply_reset();
    for (int e = 0; e < 4; e++) begin
      evt_in = 1'b1;
      tick();
    end
    evt_in = 1'b0;
    tick(); // edge 4: GAP, first cycle
    checks++;
    if (led_out !== 1'b0 || busy !== 1'b1 || pending !== 2'd3) begin
      errors++;
      $display("FAIL gapend_pre: led %b busy %b pending %0d expected 0 1 3", led_out, busy, pending);
    end
    evt_in = 1'b1;
    tick(); // edge 5: final GAP edge with a live event
    evt_in = 1'b0;
    checks++;
    if (led_out !== 1'b1 || pending !== 2'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL gapend_start: led %b pending %0d ovf %b expected 1 3 0", led_out, pending, overflow);
    end
    tick();
    checks++;
    if (led_out !== 1'b1 || pending !== 2'd3) begin
      errors++;
      $display("FAIL gapend_hold: led %b pending %0d expected 1 3", led_out, pending);
    end
  endtask

  task automatic test_reset_mid_on();
    int seen;
    apply_reset();
    for (int e = 0; e < 3; e++) begin
      evt_in = 1'b1;
      tick();
    end
    evt_in = 1'b0;
    checks++;
    if (led_out !== 1'b1 || pending !== 2'd2) begin
      errors++;
      $display("FAIL midon_pre: led %b pending %0d expected 1 2", led_out, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led_out, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL midon_async: got %b expected 00000", {led_out, busy, pending, overflow});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (led_out || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midon_no_resume: got %0d active edges expected 0", seen);
    end
  endtask

  task automatic test_clr_same_edge();
    apply_reset();
    for (int e = 0; e < 4; e++) begin
      evt_in = 1'b1;
      tick();
    end
    clr_ovf = 1'b1; // edge 4: drop and clear together
    tick();
    checks++;
    if (overflow !== 1'b1 || pending !== 2'd3) begin
      errors++;
      $display("FAIL clr_drop_wins: ovf %b pending %0d expected 1 3", overflow, pending);
    end
    evt_in = 1'b0; // edge 5: clear alone, GAP end dequeues
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0 || pending !== 2'd2 || led_out !== 1'b1) begin
      errors++;
      $display("FAIL clr_alone: ovf %b pending %0d led %b expected 0 2 1", overflow, pending, led_out);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    evt_in  = 1'b0;
    clr_ovf = 1'b0;
    #1;
    test_reset();
    test_single();
    test_burst(4);
    test_burst(5);
    test_evt_at_gap_end();
    test_reset_mid_on();
    test_clr_same_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
